// File: rtl/dma_if.sv
// dma_if: device, CPU-bus and memory-write signals of the DMA engine.
//
// Handshakes:
//   bus_req/bus_grant: the engine raises bus_req and owns the bus only in
//   cycles where bus_grant is high. It never drives a write without grant.
//   mem_write/mem_ack: mem_write is the valid and mem_ack is the ready. A word
//   transfers at a rising clk edge where both are high. While mem_write is
//   high and mem_ack is low, mem_addr and mem_data are held stable. mem_ack
//   with mem_write low has no effect.
interface dma_if #(
  parameter int WORD_SIZE       = 16,
  parameter int WORDS_PER_BLOCK = 4,
  parameter int OFFSET_BITS     = 2
);
  logic                                 dev_interrupt;
  logic [WORDS_PER_BLOCK*WORD_SIZE-1:0] dev_data;
  logic [OFFSET_BITS-1:0]               dev_offset;
  logic [WORD_SIZE-1:0]                 base_addr;
  logic                                 bus_req;
  logic                                 bus_grant;
  logic                                 mem_write;
  logic [WORD_SIZE-1:0]                 mem_addr;
  logic [WORD_SIZE-1:0]                 mem_data;
  logic                                 mem_ack;
  logic                                 dma_end;
  logic                                 busy;

  // DMA engine side
  modport master (
    input  dev_interrupt, dev_data, base_addr, bus_grant, mem_ack,
    output dev_offset, bus_req, mem_write, mem_addr, mem_data, dma_end, busy
  );

  // Environment side: device, CPU and memory
  modport slave (
    output dev_interrupt, dev_data, base_addr, bus_grant, mem_ack,
    input  dev_offset, bus_req, mem_write, mem_addr, mem_data, dma_end, busy
  );
endinterface

// File: rtl/dma_controller.sv
// dma_controller: bus-master DMA engine. On a rising interrupt edge it
// requests the bus, reads NUM_BLOCKS device blocks and writes each one to
// memory as WORDS_PER_BLOCK words (least-significant word first) starting at
// the sampled base address, then pulses dma_end.
// Optional build macro DMA_CYCLE_STEAL_EN: release the bus for one cycle
// between blocks (state S_YIELD) so the CPU can regain it.
module dma_controller #(
  parameter int WORD_SIZE       = 16,
  parameter int NUM_BLOCKS      = 3,
  parameter int WORDS_PER_BLOCK = 4,
  parameter int OFFSET_BITS     = 2
) (
  input  logic       clk,
  input  logic       reset,
  dma_if.master      bus,
  output logic [2:0] dbg_state
);
  localparam int DATA_W    = WORDS_PER_BLOCK * WORD_SIZE;
  localparam int WORD_BITS = $clog2(WORDS_PER_BLOCK);
  localparam logic [WORD_BITS-1:0]   LAST_WRD = WORD_BITS'(WORDS_PER_BLOCK - 1);
  localparam logic [OFFSET_BITS-1:0] LAST_BLK = OFFSET_BITS'(NUM_BLOCKS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_LOAD,
    S_WRITE,
    S_DONE
`ifdef DMA_CYCLE_STEAL_EN
    , S_YIELD
`endif
  } state_t;

  state_t                 state;
  state_t                 state_next;
  logic                   int_q;
  logic [WORD_SIZE-1:0]   addr_reg;
  logic [OFFSET_BITS-1:0] blk;
  logic [WORD_BITS-1:0]   wrd;
  logic [DATA_W-1:0]      blk_buf;
  logic                   accept;
  logic                   word_done;

  // A level held high or an edge outside IDLE never starts a transfer.
  assign accept    = bus.dev_interrupt & ~int_q & (state == S_IDLE);
  assign word_done = (state == S_WRITE) & bus.bus_grant & bus.mem_ack;

  assign bus.busy       = (state != S_IDLE);
  assign bus.dev_offset = blk;
  assign bus.mem_addr   = (state == S_WRITE)
                          ? addr_reg + WORD_SIZE'(blk) * WORD_SIZE'(WORDS_PER_BLOCK)
                            + WORD_SIZE'(wrd)
                          : '0;
  assign bus.mem_data   = (state == S_WRITE) ? blk_buf[WORD_SIZE*wrd +: WORD_SIZE] : '0;
  assign dbg_state      = state;

  // State register; reset aborts any transfer and releases the bus at once.
  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_next;
  end

  // Next-state and bus/handshake outputs.
  always_comb begin
    state_next    = state;
    bus.bus_req   = 1'b0;
    bus.mem_write = 1'b0;
    bus.dma_end   = 1'b0;
    case (state)
      S_IDLE: begin
        if (accept) state_next = S_REQ;
      end
      S_REQ: begin
        bus.bus_req = 1'b1;
        if (bus.bus_grant) state_next = S_LOAD;
      end
      S_LOAD: begin
        bus.bus_req = 1'b1;
        if (bus.bus_grant) state_next = S_WRITE;
      end
      S_WRITE: begin
        bus.bus_req   = 1'b1;
        bus.mem_write = bus.bus_grant;
        if (word_done && (wrd == LAST_WRD)) begin
          if (blk != LAST_BLK) begin
`ifdef DMA_CYCLE_STEAL_EN
            state_next = S_YIELD;
`else
            state_next = S_LOAD;
`endif
          end else begin
            state_next = S_DONE;
          end
        end
      end
      S_DONE: begin
        bus.dma_end = 1'b1;
        state_next  = S_IDLE;
      end
`ifdef DMA_CYCLE_STEAL_EN
      S_YIELD: begin
        state_next = S_REQ;
      end
`endif
      default: state_next = S_IDLE;
    endcase
  end

  // Datapath: interrupt edge register, base latch, block/word counters, buffer.
  always_ff @(posedge clk) begin
    if (reset) begin
      int_q    <= 1'b0;
      addr_reg <= '0;
      blk      <= '0;
      wrd      <= '0;
      blk_buf  <= '0;
    end else begin
      int_q <= bus.dev_interrupt;
      if (accept) begin
        addr_reg <= bus.base_addr;
        blk      <= '0;
        wrd      <= '0;
      end
      if ((state == S_LOAD) && bus.bus_grant) blk_buf <= bus.dev_data;
      if (word_done) begin
        if (wrd != LAST_WRD) begin
          wrd <= wrd + 1'b1;
        end else begin
          wrd <= '0;
          // Clearing blk after the last block drives offset 0 during S_DONE.
          blk <= (blk == LAST_BLK) ? '0 : blk + 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_dma_controller.sv
// tb_dma_controller: directed vector table, hand-written reset/reentrancy
// sequences and randomized transfers checked against a word-list model.
module tb_dma_controller;
  localparam int NB = 3;
`ifdef DMA_CYCLE_STEAL_EN
  localparam int STEAL_CYC  = 2 * (NB - 1);
  localparam int EXP_YIELDS = NB - 1;
`else
  localparam int STEAL_CYC  = 0;
  localparam int EXP_YIELDS = 0;
`endif

  typedef struct {
    logic [15:0] base;
    logic [63:0] d0;
    logic [63:0] d1;
    logic [63:0] d2;
    int          gnt_at;
    int          gnt_len;
    int          ack_at;
    int          ack_len;
    int          int_mode;
    int          exp_cycles;
    logic [15:0] exp_last;
  } vec_t;

  // ---------------- clock / reset ----------------
  logic       clk = 1'b0;
  logic       reset;
  logic [2:0] dbg_state;
  always #5 clk = ~clk;

  dma_if bus_if();

  dma_controller dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus_if),
    .dbg_state (dbg_state)
  );

  // Device model: block selected by dev_offset.
  logic [63:0] blk_tbl[4];
  assign bus_if.dev_data = blk_tbl[bus_if.dev_offset];

  // ---------------- scoreboard state ----------------
  int          checks = 0;
  int          errors = 0;
  logic [15:0] exp_addr_q[$];
  logic [15:0] exp_data_q[$];
  int          words_done, dma_end_cnt, busy_cycles, yield_cnt, cyc;
  logic [15:0] last_addr, base_cur;
  bit          end_seen;
  int          gnt_at, gnt_len, ack_at, ack_len, gnt_left, ack_left, int_mode;
  bit          gnt_used, ack_used, rand_stall, gnt_forced;
  vec_t        vecs[5];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    errors++;
    $display("FAIL %s (no progress or unexpected event)", name);
  endtask

  // Reference: the 12 expected writes, derived from base and the device blocks.
  task automatic prep_model(input logic [15:0] base);
    exp_addr_q.delete();
    exp_data_q.delete();
    for (int b = 0; b < NB; b++)
      for (int w = 0; w < 4; w++) begin
        exp_addr_q.push_back(base + 16'(4 * b + w));
        exp_data_q.push_back(blk_tbl[b][16*w +: 16]);
      end
    base_cur    = base;
    words_done  = 0;
    dma_end_cnt = 0;
    busy_cycles = 0;
    yield_cnt   = 0;
    cyc         = 0;
    end_seen    = 1'b0;
    last_addr   = '0;
    gnt_left    = 0;
    ack_left    = 0;
    gnt_used    = 1'b0;
    ack_used    = 1'b0;
    bus_if.base_addr = base;
  endtask

  // ---------------- driver ----------------
  task automatic drive_cycle();
    logic g, a;
    @(posedge clk);
    #1;
    cyc++;
    case (int_mode)
      1:       bus_if.dev_interrupt = (cyc <= 2) || (cyc >= 7);
      default: bus_if.dev_interrupt = (cyc <= 2);
    endcase
    g = bus_if.bus_req;
    gnt_forced = 1'b0;
    if (gnt_left > 0) begin
      gnt_left--;
      g = 1'b0;
      gnt_forced = 1'b1;
    end else if (!gnt_used && bus_if.bus_req && words_done == gnt_at) begin
      gnt_used = 1'b1;
      gnt_left = gnt_len - 1;
      g = 1'b0;
      gnt_forced = 1'b1;
    end else if (rand_stall && $urandom_range(0, 3) == 0) begin
      g = 1'b0;
    end
    a = 1'b1;
    if (ack_left > 0) begin
      ack_left--;
      a = 1'b0;
    end else if (!ack_used && bus_if.bus_req && words_done == ack_at) begin
      ack_used = 1'b1;
      ack_left = ack_len - 1;
      a = 1'b0;
    end else if (rand_stall && $urandom_range(0, 2) == 0) begin
      a = 1'b0;
    end
    bus_if.bus_grant = g;
    bus_if.mem_ack   = a;
  endtask

  // ---------------- monitor (called at negedge) ----------------
  task automatic monitor_sample();
    if (bus_if.mem_write) check("wr_has_grant", 32'(bus_if.bus_grant), 32'd1);
    if (gnt_forced && bus_if.busy) check("req_held_in_stall", 32'(bus_if.bus_req), 32'd1);
    if (bus_if.mem_write && bus_if.mem_ack) begin
      if (exp_addr_q.size() == 0) begin
        fail_now("extra_write");
      end else begin
        check("wr_addr", 32'(bus_if.mem_addr), 32'(exp_addr_q.pop_front()));
        check("wr_data", 32'(bus_if.mem_data), 32'(exp_data_q.pop_front()));
      end
      last_addr = bus_if.mem_addr;
      words_done++;
    end
    if (bus_if.busy) busy_cycles++;
    if (bus_if.dma_end) begin
      dma_end_cnt++;
      end_seen = 1'b1;
      check("end_offset", 32'(bus_if.dev_offset), 32'd0);
    end
    if (bus_if.busy && !bus_if.bus_req && !bus_if.dma_end) begin
      yield_cnt++;
      check("yield_after_addr", 32'(last_addr), 32'(base_cur + 16'(4 * yield_cnt - 1)));
    end
  endtask

  // One full transfer from interrupt to idle, then post-checks.
  task automatic run_xfer(input int exp_cycles, input logic [15:0] exp_last);
    int post;
    post = 0;
    for (int c = 0; c < 300; c++) begin
      drive_cycle();
      @(negedge clk);
      monitor_sample();
      if (end_seen) post++;
      if (post == 8) break;
    end
    if (post < 8) fail_now("xfer_timeout");
    check("idle_busy", 32'(bus_if.busy), 32'd0);
    check("words_left", 32'(exp_addr_q.size()), 32'd0);
    check("dma_end_count", 32'(dma_end_cnt), 32'd1);
    check("last_addr", 32'(last_addr), 32'(exp_last));
    check("yield_count", 32'(yield_cnt), 32'(EXP_YIELDS));
    if (exp_cycles > 0) check("busy_cycles", 32'(busy_cycles), 32'(exp_cycles));
    @(posedge clk);
    #1;
    bus_if.dev_interrupt = 1'b0;
    bus_if.bus_grant     = 1'b0;
    bus_if.mem_ack       = 1'b0;
    @(posedge clk);
    #1;
  endtask

  // ---------------- main sequence ----------------
  initial begin
    reset = 1'b1;
    bus_if.dev_interrupt = 1'b0;
    bus_if.base_addr     = '0;
    bus_if.bus_grant     = 1'b0;
    bus_if.mem_ack       = 1'b0;
    for (int i = 0; i < 4; i++) blk_tbl[i] = '0;
    gnt_at = -1; gnt_len = 0; ack_at = -1; ack_len = 0;
    int_mode = 0; rand_stall = 1'b0; gnt_forced = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_bus_req",   32'(bus_if.bus_req),    32'd0);
    check("rst_mem_write", 32'(bus_if.mem_write),  32'd0);
    check("rst_mem_addr",  32'(bus_if.mem_addr),   32'd0);
    check("rst_mem_data",  32'(bus_if.mem_data),   32'd0);
    check("rst_dev_offset",32'(bus_if.dev_offset), 32'd0);
    check("rst_dma_end",   32'(bus_if.dma_end),    32'd0);
    check("rst_busy",      32'(bus_if.busy),       32'd0);
    @(posedge clk);
    #1 reset = 1'b0;

    // base, blocks 0..2, grant gap (at word, len), ack gap (at word, len),
    // interrupt mode, busy cycles, last written address
    vecs[0] = '{16'h01F4, 64'hAAAA_AAAA_AAAA_AAAA, 64'hBBBB_BBBB_BBBB_BBBB,
                64'hCCCC_CCCC_CCCC_CCCC, -1, 0, -1, 0, 0, 17 + STEAL_CYC, 16'h01FF};
    vecs[1] = '{16'h1000, 64'h4444_3333_2222_1111, 64'h8888_7777_6666_5555,
                64'hDEAD_BEEF_0123_4567, -1, 0, -1, 0, 0, 17 + STEAL_CYC, 16'h100B};
    vecs[2] = '{16'h01F4, 64'hAAAA_AAAA_AAAA_AAAA, 64'hBBBB_BBBB_BBBB_BBBB,
                64'hCCCC_CCCC_CCCC_CCCC, 6, 5, 9, 3, 0, 25 + STEAL_CYC, 16'h01FF};
    vecs[3] = '{16'hFFFC, 64'h0A0A_0909_0808_0707, 64'h1111_2222_3333_4444,
                64'h5555_6666_7777_8888, -1, 0, -1, 0, 1, 17 + STEAL_CYC, 16'h0007};
    vecs[4] = '{16'hFFFF, 64'hF00D_CAFE_BABE_FACE, 64'h0102_0304_0506_0708,
                64'h1357_9BDF_2468_ACE0, -1, 0, -1, 0, 0, 17 + STEAL_CYC, 16'h000A};

    for (int v = 0; v < 5; v++) begin
      blk_tbl[0] = vecs[v].d0;
      blk_tbl[1] = vecs[v].d1;
      blk_tbl[2] = vecs[v].d2;
      gnt_at = vecs[v].gnt_at; gnt_len = vecs[v].gnt_len;
      ack_at = vecs[v].ack_at; ack_len = vecs[v].ack_len;
      int_mode = vecs[v].int_mode;
      rand_stall = 1'b0;
      prep_model(vecs[v].base);
      run_xfer(vecs[v].exp_cycles, vecs[v].exp_last);
    end

    // Reset during block 1: immediate abort, no dma_end, then a clean rerun.
    gnt_at = -1; ack_at = -1; int_mode = 0; rand_stall = 1'b0;
    blk_tbl[0] = 64'h0123_4567_89AB_CDEF;
    blk_tbl[1] = 64'h1111_2222_3333_4444;
    blk_tbl[2] = 64'h5555_6666_7777_8888;
    prep_model(16'h0200);
    for (int c = 0; c < 100 && words_done < 5; c++) begin
      drive_cycle();
      @(negedge clk);
      monitor_sample();
    end
    if (words_done < 5) fail_now("abort_reach_timeout");
    @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    #1;
    check("abort_bus_req",   32'(bus_if.bus_req),   32'd0);
    check("abort_mem_write", 32'(bus_if.mem_write), 32'd0);
    check("abort_busy",      32'(bus_if.busy),      32'd0);
    check("abort_dma_end",   32'(bus_if.dma_end),   32'd0);
    check("abort_end_count", 32'(dma_end_cnt),      32'd0);
    reset = 1'b0;
    bus_if.bus_grant = 1'b0;
    bus_if.mem_ack   = 1'b0;
    @(posedge clk);
    #1;
    prep_model(16'h0300);
    run_xfer(17 + STEAL_CYC, 16'h030B);

    // Randomized transfers with random grant/ack stalls.
    for (int r = 0; r < 8; r++) begin
      logic [15:0] base;
      base = ($urandom_range(0, 3) == 0) ? 16'(16'hFFF0 + $urandom_range(0, 15))
                                        : 16'($urandom);
      for (int b = 0; b < NB; b++) blk_tbl[b] = {$urandom, $urandom};
      gnt_at = -1; ack_at = -1; int_mode = r % 2; rand_stall = 1'b1;
      prep_model(base);
      run_xfer(-1, base + 16'd11);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
